// File: rtl/sha256_pkg.sv
// Shared SHA-256 payload types: the eight-word working context and schedule sizes.
package sha256_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ROUNDS = 64;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
    logic [WORD_W-1:0] e;
    logic [WORD_W-1:0] f;
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] h;
  } ShaContext;

endpackage

// File: rtl/sha256_compress_arbiter_if.sv
// Requester and compressor handshake bundle for sha256_compress_arbiter.
// master = arbiter view, slave = requesters/compressor view.
interface sha256_compress_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]                                               req_vld;
  logic [NUM_REQ-1:0]                                               req_rdy;
  logic [NUM_REQ-1:0][sha256_pkg::ROUNDS-1:0][sha256_pkg::WORD_W-1:0] req_w;
  sha256_pkg::ShaContext [NUM_REQ-1:0]                              req_ctx;

  logic [NUM_REQ-1:0]    rsp_vld;
  logic [NUM_REQ-1:0]    rsp_rdy;
  sha256_pkg::ShaContext rsp_ctx;
  logic                  rsp_err;

  logic                                                 core_w_rdy;
  logic                                                 core_w_vld;
  logic [sha256_pkg::ROUNDS-1:0][sha256_pkg::WORD_W-1:0] core_w;

  logic                  core_ctx_in_rdy;
  logic                  core_ctx_in_vld;
  sha256_pkg::ShaContext core_ctx_in;

  logic                  core_ctx_out_rdy;
  logic                  core_ctx_out_vld;
  sha256_pkg::ShaContext core_ctx_out;

  modport master (
    input  req_vld, req_w, req_ctx, rsp_rdy,
    input  core_w_rdy, core_ctx_in_rdy, core_ctx_out_vld, core_ctx_out,
    output req_rdy, rsp_vld, rsp_ctx, rsp_err,
    output core_w_vld, core_w, core_ctx_in_vld, core_ctx_in, core_ctx_out_rdy
  );

  modport slave (
    output req_vld, req_w, req_ctx, rsp_rdy,
    output core_w_rdy, core_ctx_in_rdy, core_ctx_out_vld, core_ctx_out,
    input  req_rdy, rsp_vld, rsp_ctx, rsp_err,
    input  core_w_vld, core_w, core_ctx_in_vld, core_ctx_in, core_ctx_out_rdy
  );

endinterface

// File: rtl/sha256_compress_arbiter.sv
// Round-robin sharing of one SHA-256 compression core among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining SHA_ARB_WATCHDOG_EN.
module sha256_compress_arbiter
  import sha256_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
`ifdef SHA_ARB_WATCHDOG_EN
  parameter  int unsigned TIMEOUT_CYCLES = 255,
`endif
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sha256_compress_arbiter_if.master bus,
  output logic                      busy,
  output logic [IDX_W-1:0]          owner,
  output logic [31:0]               jobs_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             w_done_q, w_done_d;
  logic             c_done_q, c_done_d;
  ShaContext        rsp_ctx_q, rsp_ctx_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      jobs_q, jobs_d;

  logic             grant_vld_c;
  logic [IDX_W-1:0] grant_idx_c;
  logic             w_hs_c;
  logic             c_hs_c;

`ifdef SHA_ARB_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  // First requester above the last winner, wrapping around.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(rr_q) + i) % NUM_REQ;
      if (!grant_vld_c && bus.req_vld[IDX_W'(cand)]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = IDX_W'(cand);
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    w_done_d = w_done_q;
    c_done_d = c_done_q;
    rsp_ctx_d = rsp_ctx_q;
    rsp_err_d = rsp_err_q;
    jobs_d   = jobs_q;
`ifdef SHA_ARB_WATCHDOG_EN
    wdog_d   = wdog_q;
`endif

    bus.req_rdy          = '0;
    bus.rsp_vld          = '0;
    bus.core_w_vld       = 1'b0;
    bus.core_ctx_in_vld  = 1'b0;
    bus.core_ctx_out_rdy = 1'b0;
    w_hs_c               = 1'b0;
    c_hs_c               = 1'b0;

    case (state_q)
      IDLE: begin
        w_done_d = 1'b0;
        c_done_d = 1'b0;
        if (grant_vld_c) begin
          owner_d = grant_idx_c;
          rr_d    = grant_idx_c;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        bus.core_w_vld      = !w_done_q;
        bus.core_ctx_in_vld = !c_done_q;
        w_hs_c   = bus.core_w_vld && bus.core_w_rdy;
        c_hs_c   = bus.core_ctx_in_vld && bus.core_ctx_in_rdy;
        w_done_d = w_done_q || w_hs_c;
        c_done_d = c_done_q || c_hs_c;
        // Job is accepted only once the core has taken both halves.
        if (w_done_d && c_done_d) begin
          bus.req_rdy[owner_q] = 1'b1;
          w_done_d = 1'b0;
          c_done_d = 1'b0;
          state_d  = WAIT;
`ifdef SHA_ARB_WATCHDOG_EN
          wdog_d   = '0;
`endif
        end
      end

      WAIT: begin
        bus.core_ctx_out_rdy = 1'b1;
        if (bus.core_ctx_out_vld) begin
          rsp_ctx_d = bus.core_ctx_out;
          state_d   = RETURN;
        end
`ifdef SHA_ARB_WATCHDOG_EN
        else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_ctx_d = '0;
          rsp_err_d = 1'b1;
          state_d   = RETURN;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end

      RETURN: begin
        bus.rsp_vld[owner_q] = 1'b1;
        if (bus.rsp_rdy[owner_q]) begin
          jobs_d    = jobs_q + 32'd1;
          rsp_err_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_q      <= IDX_W'(NUM_REQ - 1);
      w_done_q  <= 1'b0;
      c_done_q  <= 1'b0;
      rsp_ctx_q <= '0;
      rsp_err_q <= 1'b0;
      jobs_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      w_done_q  <= w_done_d;
      c_done_q  <= c_done_d;
      rsp_ctx_q <= rsp_ctx_d;
      rsp_err_q <= rsp_err_d;
      jobs_q    <= jobs_d;
    end
  end

`ifdef SHA_ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  // Core payload follows the owner directly; the requester holds it stable.
  assign bus.core_w      = bus.req_w[owner_q];
  assign bus.core_ctx_in = bus.req_ctx[owner_q];
  assign bus.rsp_ctx     = rsp_ctx_q;
  assign bus.rsp_err     = rsp_err_q;

  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
  assign jobs_done = jobs_q;

endmodule

// File: tb/tb_sha256_compress_arbiter.sv
// Directed self-checking bench for sha256_compress_arbiter; compressor is driven as stimulus.
module tb_sha256_compress_arbiter;
  import sha256_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
`ifdef SHA_ARB_WATCHDOG_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             busy;
  logic [IDX_W-1:0] owner;
  logic [31:0]      jobs_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sha256_compress_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  sha256_compress_arbiter #(
    .NUM_REQ(NUM_REQ)
`ifdef SHA_ARB_WATCHDOG_EN
   ,.TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .owner     (owner),
    .jobs_done (jobs_done)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] w_word(input int i, input int j);
    return {8'hA5, 8'(i), 16'(j)};
  endfunction

  function automatic logic [ROUNDS-1:0][WORD_W-1:0] exp_w(input int i);
    logic [ROUNDS-1:0][WORD_W-1:0] v;
    for (int j = 0; j < 64; j++) v[j] = w_word(i, j);
    return v;
  endfunction

  function automatic ShaContext in_ctx(input int i);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = {8'hC7, 8'(i), 16'(k)};
    return ShaContext'(v);
  endfunction

  function automatic ShaContext out_ctx(input int seed);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = {8'h0D, 8'(seed), 16'(k * 7 + 1)};
    return ShaContext'(v);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // One full job: grant, ISSUE with given handshake delays, WAIT, RETURN with backpressure.
  // out_dly < 0 means the core never answers (watchdog path).
  task automatic do_job(input int exp_own, input int w_dly, input int c_dly, input int out_dly,
                        input int rsp_dly, input logic [NUM_REQ-1:0] vld_after, input int exp_jobs);
    int        last;
    int        n;
    logic      seen;
    ShaContext exp_ctx;
    logic      exp_err;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("grant_seen", 256'(seen), 256'(1'b1));
    check("owner", 256'(owner), 256'(exp_own));
    check("core_w", 256'(bus.core_w == exp_w(exp_own)), 256'(1'b1));
    check("core_ctx_in", 256'(bus.core_ctx_in), 256'(in_ctx(exp_own)));

    last = (w_dly > c_dly) ? w_dly : c_dly;
    for (int t = 0; t <= last; t++) begin
      if (t > 0) @(negedge clk);
      bus.core_w_rdy      = (t == w_dly);
      bus.core_ctx_in_rdy = (t == c_dly);
      #1;
      check("core_w_vld", 256'(bus.core_w_vld), 256'(t <= w_dly));
      check("core_ctx_in_vld", 256'(bus.core_ctx_in_vld), 256'(t <= c_dly));
      check("req_rdy_issue", 256'(bus.req_rdy),
            256'((t == last) ? onehot(exp_own) : 4'b0000));
    end

    n = (out_dly < 0) ? TMO : out_dly + 1;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (t == 0) begin
        bus.core_w_rdy      = 1'b0;
        bus.core_ctx_in_rdy = 1'b0;
        bus.req_vld         = vld_after;
      end
      bus.core_ctx_out_vld = (out_dly >= 0) && (t == out_dly);
      bus.core_ctx_out     = out_ctx(exp_jobs);
      #1;
      check("ctx_out_rdy_wait", 256'(bus.core_ctx_out_rdy), 256'(1'b1));
      check("req_rdy_wait", 256'(bus.req_rdy), 256'(4'b0000));
      check("core_w_vld_wait", 256'(bus.core_w_vld), 256'(1'b0));
      check("rsp_vld_wait", 256'(bus.rsp_vld), 256'(4'b0000));
    end

    exp_ctx = (out_dly < 0) ? ShaContext'('0) : out_ctx(exp_jobs);
    exp_err = (out_dly < 0);
    for (int t = 0; t <= rsp_dly; t++) begin
      @(negedge clk);
      bus.core_ctx_out_vld = 1'b0;
      bus.core_ctx_out     = ~out_ctx(exp_jobs);
      bus.rsp_rdy          = (t == rsp_dly) ? onehot(exp_own) : ~onehot(exp_own);
      #1;
      check("rsp_vld", 256'(bus.rsp_vld), 256'(onehot(exp_own)));
      check("rsp_ctx", 256'(bus.rsp_ctx), 256'(exp_ctx));
      check("rsp_err", 256'(bus.rsp_err), 256'(exp_err));
      check("ctx_out_rdy_ret", 256'(bus.core_ctx_out_rdy), 256'(1'b0));
      check("owner_ret", 256'(owner), 256'(exp_own));
      check("busy_ret", 256'(busy), 256'(1'b1));
    end

    @(negedge clk);
    bus.rsp_rdy = '0;
    #1;
    check("busy_idle", 256'(busy), 256'(1'b0));
    check("rsp_vld_idle", 256'(bus.rsp_vld), 256'(4'b0000));
    check("rsp_err_idle", 256'(bus.rsp_err), 256'(1'b0));
    check("jobs_done", 256'(jobs_done), 256'(exp_jobs));
  endtask

  initial begin
    logic seen;
    rst_n                = 1'b0;
    bus.req_vld          = '0;
    bus.rsp_rdy          = '0;
    bus.core_w_rdy       = 1'b0;
    bus.core_ctx_in_rdy  = 1'b0;
    bus.core_ctx_out_vld = 1'b0;
    bus.core_ctx_out     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ctx[i] = in_ctx(i);
      for (int j = 0; j < 64; j++) bus.req_w[i][j] = w_word(i, j);
    end

    repeat (3) @(negedge clk);
    check("rst_busy", 256'(busy), 256'(1'b0));
    check("rst_owner", 256'(owner), 256'(2'd0));
    check("rst_jobs", 256'(jobs_done), 256'(32'd0));
    check("rst_req_rdy", 256'(bus.req_rdy), 256'(4'b0000));
    check("rst_rsp_vld", 256'(bus.rsp_vld), 256'(4'b0000));
    check("rst_rsp_ctx", 256'(bus.rsp_ctx), 256'(0));
    check("rst_rsp_err", 256'(bus.rsp_err), 256'(1'b0));
    check("rst_core_vld", 256'({bus.core_w_vld, bus.core_ctx_in_vld, bus.core_ctx_out_rdy}),
          256'(3'b000));

    // Single job from requester 2, core answers on the 66th WAIT cycle.
    @(negedge clk);
    rst_n       = 1'b1;
    bus.req_vld = 4'b0100;
    do_job(2, 0, 0, 65, 0, 4'b0000, 1);

    // Split handshakes, w first then ctx_in, and the reverse.
    bus.req_vld = 4'b0001;
    do_job(0, 0, 3, 4, 0, 4'b0000, 2);
    bus.req_vld = 4'b1000;
    do_job(3, 2, 0, 4, 0, 4'b0000, 3);

    // Result backpressure with competing requests pending.
    bus.req_vld = 4'b0010;
    do_job(1, 0, 0, 3, 20, 4'b1101, 4);

    // Reset in WAIT: next job after reset must go to requester 2 first, then reset.
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("grant_seen_rr", 256'(seen), 256'(1'b1));
    check("owner_after_bp", 256'(owner), 256'(2'd2));
    bus.core_w_rdy      = 1'b1;
    bus.core_ctx_in_rdy = 1'b1;
    @(negedge clk);
    bus.core_w_rdy      = 1'b0;
    bus.core_ctx_in_rdy = 1'b0;
    #1;
    check("wait_before_rst", 256'(bus.core_ctx_out_rdy), 256'(1'b1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 256'(busy), 256'(1'b0));
    check("midrst_ctx_out_rdy", 256'(bus.core_ctx_out_rdy), 256'(1'b0));
    check("midrst_owner", 256'(owner), 256'(2'd0));
    check("midrst_jobs", 256'(jobs_done), 256'(32'd0));
    check("midrst_rsp_vld", 256'(bus.rsp_vld), 256'(4'b0000));
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    bus.req_vld = 4'b1111;

    // Fairness: all requesting, grants rotate 0..3 twice.
    for (int i = 0; i < 8; i++) begin
      do_job(i % 4, i % 3, (i + 1) % 3, 2 + i, i % 2, 4'b1111, i + 1);
    end

`ifdef SHA_ARB_WATCHDOG_EN
    // Core never answers: timeout return with zero context and error flag.
    do_job(0, 0, 0, -1, 2, 4'b0000, 9);
`endif

    bus.req_vld = '0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
